regfile_issue: RTL and testbench

//  Operand-fetch/issue stage directly upstream of the ALU. Holds the 32x32 register file.

---
 rtl/alu_pkg.sv | 13 +
 rtl/regfile_core.sv | 35 +++
 rtl/regfile_issue.sv | 92 +++++++++
 tb/tb_regfile_issue.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared widths and ALU operation codes for the operand-fetch/issue stage and the ALU.
package alu_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_OP_W   = 5;

  localparam logic [DEF_OP_W-1:0] ALUOP_SUB = 5'b00000;
  localparam logic [DEF_OP_W-1:0] ALUOP_ADD = 5'b00001;
  localparam logic [DEF_OP_W-1:0] ALUOP_MUL = 5'b00010;
  localparam logic [DEF_OP_W-1:0] ALUOP_OR  = 5'b00011;

endpackage

// File: rtl/regfile_core.sv
// Register file storage: two asynchronous read ports, one synchronous write port.
// x0 is hardwired to zero.
module regfile_core
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/regfile_issue.sv
// Operand-fetch/issue stage: register file, pending-write scoreboard, write-back bypass
// and a registered valid/ready output slot feeding the ALU.
module regfile_issue
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int OP_W   = DEF_OP_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [OP_W-1:0]   in_aluop,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [OP_W-1:0]   out_aluop,
  output logic [ADDR_W-1:0] out_rd
);

  localparam int NREG = 1 << ADDR_W;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // in_ready never depends on in_valid, and out_* stay frozen while out_valid && !out_ready.

  logic [DATA_W-1:0] rf_a, rf_b, src_a, src_b;
  logic [NREG-1:0]   pending, pending_nxt;
  logic              wb_hit, haz, accept;

  regfile_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_core (
    .clk  (clk),
    .rstn (rstn),
    .ra1  (in_rs1),
    .ra2  (in_rs2),
    .rd1  (rf_a),
    .rd2  (rf_b),
    .we   (wb_en),
    .wa   (wb_addr),
    .wd   (wb_data)
  );

  assign wb_hit = wb_en && (wb_addr != '0);

  // Write-through: a result landing this cycle is visible to the op reading it.
  assign src_a = (wb_hit && wb_addr == in_rs1) ? wb_data : rf_a;
  assign src_b = (wb_hit && wb_addr == in_rs2) ? wb_data : rf_b;

  assign haz = (pending[in_rs1] && !(wb_en && wb_addr == in_rs1)) ||
               (pending[in_rs2] && !(wb_en && wb_addr == in_rs2));

  assign in_ready = (!out_valid || out_ready) && !haz;
  assign accept   = in_valid && in_ready;

  // Clear before set so a same-cycle wb and accept on one rd leaves the new op pending.
  always_comb begin
    pending_nxt = pending;
    if (wb_hit) pending_nxt[wb_addr] = 1'b0;
    if (accept && in_rd != '0) pending_nxt[in_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pending <= '0;
    else       pending <= pending_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_aluop <= '0;
      out_rd    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_a     <= src_a;
      out_b     <= src_b;
      out_aluop <= in_aluop;
      out_rd    <= in_rd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_issue.sv
// Self-checking bench for regfile_issue: vector table plus hand-written hazard, stall,
// x0 and reset sequences, with issued ops checked against an expected queue.
module tb_regfile_issue;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd, in_aluop;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_a, out_b;
  logic [4:0]  out_aluop, out_rd;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [73:0] exp_q[$];

  regfile_issue dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_aluop(in_aluop),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_aluop(out_aluop), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [73:0] act, input logic [73:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected entry layout: {a[73:42], b[41:10], aluop[9:5], rd[4:0]}
  always @(negedge clk) begin
    logic [73:0] e;
    if (rstn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_issue: got a=%0h b=%0h with no expected entry", out_a, out_b);
      end else begin
        e = exp_q.pop_front();
        chk("issue_a",     out_a,     e[73:42]);
        chk("issue_b",     out_b,     e[41:10]);
        chk("issue_aluop", out_aluop, e[9:5]);
        chk("issue_rd",    out_rd,    e[4:0]);
      end
    end
  end

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    wb_en = 1'b1; wb_addr = addr; wb_data = data;
    @(posedge clk); #1;
    wb_en = 1'b0;
  endtask

  // Presents an op and waits for acceptance; leaves in_valid high for back-to-back use.
  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [4:0] op, input logic [31:0] ea, input logic [31:0] eb,
                       input int max_wait, output int waited);
    bit ok = 0;
    in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_aluop = op;
    waited = 0;
    while (!ok && waited <= max_wait) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      else begin
        waited++;
        @(posedge clk); #1;
      end
    end
    if (!ok) begin
      chk_cnt++;
      $display("FAIL issue_timeout: rs1=%0d rs2=%0d not accepted within %0d cycles", rs1, rs2, max_wait);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back({ea, eb, op, rd});
      #1;
    end
  endtask

  task automatic drain_check(input string name);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(name, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wbv_t;

  typedef struct {
    logic [4:0]  rs1, rs2, rd, op;
    logic [31:0] ea, eb;
  } vec_t;

  wbv_t preload[6];
  vec_t vecs[6];

  initial begin
    int w;
    preload[0] = '{5'd1, 32'h1111_1111};
    preload[1] = '{5'd2, 32'hA5A5_A5A5};
    preload[2] = '{5'd3, 32'd7};
    preload[3] = '{5'd4, 32'd5};
    preload[4] = '{5'd7, 32'hDEAD_BEEF};
    preload[5] = '{5'd8, 32'hFFFF_FFFF};

    vecs[0] = '{5'd3, 5'd4, 5'd6,  ALUOP_ADD, 32'd7,         32'd5};
    vecs[1] = '{5'd1, 5'd2, 5'd0,  ALUOP_SUB, 32'h1111_1111, 32'hA5A5_A5A5};
    vecs[2] = '{5'd0, 5'd7, 5'd0,  ALUOP_MUL, 32'd0,         32'hDEAD_BEEF};
    vecs[3] = '{5'd8, 5'd8, 5'd0,  ALUOP_OR,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4] = '{5'd2, 5'd1, 5'd11, ALUOP_ADD, 32'hA5A5_A5A5, 32'h1111_1111};
    vecs[5] = '{5'd3, 5'd3, 5'd3,  ALUOP_SUB, 32'd7,         32'd7};

    rstn = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_aluop = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_a",     out_a,     0);
    chk("rst_out_b",     out_b,     0);
    chk("rst_out_aluop", out_aluop, 0);
    chk("rst_out_rd",    out_rd,    0);
    chk("rst_in_ready",  in_ready,  1);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    foreach (preload[i]) wb_write(preload[i].addr, preload[i].data);

    // Back-to-back vectors: each must be taken in its first cycle.
    foreach (vecs[i]) begin
      issue(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].op, vecs[i].ea, vecs[i].eb, 0, w);
      chk("tput_wait", w, 0);
    end
    in_rs1 = 5'd3; in_rs2 = 5'd0; in_rd = 5'd0;
    @(negedge clk);
    chk("rd_eq_rs_stall", in_ready, 0);
    @(posedge clk); #1;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'd9;
    issue(5'd3, 5'd4, 5'd0, ALUOP_ADD, 32'd9, 32'd5, 0, w);
    wb_en = 1'b0; in_valid = 1'b0;
    wb_write(5'd6, 32'h66);
    wb_write(5'd11, 32'hBB);
    drain_check("drain_vectors");

    // RAW stall resolved by bypass in the write-back cycle.
    issue(5'd3, 5'd4, 5'd10, ALUOP_ADD, 32'd9, 32'd5, 0, w);
    in_rs1 = 5'd10; in_rs2 = 5'd3; in_rd = 5'd0; in_aluop = ALUOP_SUB;
    repeat (2) begin
      @(negedge clk);
      chk("raw_stall", in_ready, 0);
      @(posedge clk); #1;
    end
    wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'd12;
    issue(5'd10, 5'd3, 5'd0, ALUOP_SUB, 32'd12, 32'd9, 0, w);
    chk("bypass_wait", w, 0);
    wb_en = 1'b0;
    issue(5'd10, 5'd0, 5'd0, ALUOP_OR, 32'd12, 32'd0, 0, w);
    chk("pending_cleared", w, 0);
    drain_check("drain_raw");

    // Output back-pressure: held op stays stable, queued op waits.
    out_ready = 1'b0;
    issue(5'd4, 5'd3, 5'd0, ALUOP_MUL, 32'd5, 32'd9, 0, w);
    in_rs1 = 5'd1; in_rs2 = 5'd0; in_rd = 5'd0; in_aluop = ALUOP_ADD;
    repeat (3) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_a",     out_a,     32'd5);
      chk("hold_b",     out_b,     32'd9);
      chk("hold_aluop", out_aluop, ALUOP_MUL);
      chk("hold_ready", in_ready,  0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    issue(5'd1, 5'd0, 5'd0, ALUOP_ADD, 32'h1111_1111, 32'd0, 0, w);
    chk("release_wait", w, 0);
    drain_check("drain_hold");

    // x0: write ignored, no bypass, never pending.
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    issue(5'd0, 5'd0, 5'd0, ALUOP_OR, 32'd0, 32'd0, 0, w);
    wb_en = 1'b0;
    issue(5'd0, 5'd3, 5'd0, ALUOP_ADD, 32'd0, 32'd9, 0, w);
    chk("x0_no_pending", w, 0);
    drain_check("drain_x0");

    // Same-cycle wb clear and accept set on x9 leaves x9 pending.
    issue(5'd3, 5'd4, 5'd9, ALUOP_ADD, 32'd9, 32'd5, 0, w);
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
    issue(5'd1, 5'd2, 5'd9, ALUOP_SUB, 32'h1111_1111, 32'hA5A5_A5A5, 0, w);
    wb_en = 1'b0;
    in_rs1 = 5'd9; in_rs2 = 5'd0; in_rd = 5'd0; in_aluop = ALUOP_OR;
    repeat (3) begin
      @(negedge clk);
      chk("pend9_stall", in_ready, 0);
      @(posedge clk); #1;
    end
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h1234;
    issue(5'd9, 5'd0, 5'd0, ALUOP_OR, 32'h1234, 32'd0, 0, w);
    chk("pend9_wait", w, 0);
    wb_en = 1'b0;
    drain_check("drain_set_clear");

    // Reset with an op held in the output slot.
    out_ready = 1'b0;
    issue(5'd3, 5'd4, 5'd5, ALUOP_ADD, 32'd9, 32'd5, 0, w);
    in_valid = 1'b0;
    @(posedge clk); #3;
    chk("pre_reset_valid", out_valid, 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_a",     out_a,     0);
    chk("mid_rst_b",     out_b,     0);
    chk("mid_rst_aluop", out_aluop, 0);
    chk("mid_rst_rd",    out_rd,    0);
    exp_q.delete();
    @(negedge clk); rstn = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    issue(5'd5, 5'd3, 5'd0, ALUOP_ADD, 32'd0, 32'd0, 0, w);
    chk("post_rst_no_pending", w, 0);
    drain_check("drain_reset");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
